uart_rx_engine: RTL and testbench
=================================

Name: uart_rx_engine

Overview:
- Serial receive datapath of the UART: oversampling receiver that deserialises asynchronous frames (start, data LSB-first, optional parity, stop) into parallel bytes.
- Received bytes and status are presented on a valid/ready interface to the UART core.
- Mirror of the transmit path; framing configuration is driven by CSR fields.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, oversample ticks per bit period (even, >=4)
DIV_W, 16, width of the baud divisor

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
baud_div  input  DIV_W  oversample tick period minus 1, in clk cycles
parity_en  input  1  1 = frame carries a parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
rx_i  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte
rx_valid  output  1  rx_data/flags valid
rx_ready  input  1  consumer accepts byte
frame_err  output  1  stop bit sampled 0; qualified by rx_valid
parity_err  output  1  parity mismatch; qualified by rx_valid
overrun  output  1  one-cycle pulse: completed frame dropped
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n=0 on a clk edge) forces the following: state IDLE; rx_data 0; rx_valid, frame_err, parity_err, overrun, busy all 0; synchroniser flops 1; counters 0. Reset mid-frame abandons the frame; no partial output.
- rx_i passes through a 2-flop synchroniser (reset to 1). All decisions use the synchronised value rxs.
- Tick generator: cnt counts 0..div_q, where div_q = baud_div latched at start detect. Tick when cnt==div_q, then cnt<=0. baud_div=0 gives a tick every cycle. baud_div changes mid-frame are ignored.
- States and transitions:
  - IDLE: rxs==0 latches div_q, clears cnt and tick counter tc -> START.
  - START: on tick, tc++. At tc==OVERSAMPLE/2-1, sample. Sample 1 -> IDLE (false start, no output). Sample 0 -> tc<=0, bit index <=0 -> DATA.
  - DATA: sample each time tc reaches OVERSAMPLE-1 (bit centre), then tc<=0. Shift sample into position bit index (LSB first). After DATA_BITS samples -> PARITY if parity_en, else STOP.
  - PARITY: sample at bit centre. parity_err_n = (XOR of data bits ^ sample ^ parity_odd) != 0 -> STOP.
  - STOP: sample at bit centre; frame_err_n = ~sample. Then load output, next state IDLE when the sample is 1, else BREAK_WAIT.
  - BREAK_WAIT: stay until rxs==1 -> IDLE.
  - parity_en/parity_odd are sampled at start detect.
- Output load: occurs on the cycle after the stop sample. rx_valid=1 from that cycle.
  - Load sets rx_data, frame_err and parity_err together.
  - Frame-error and parity-error bytes are still delivered.
- Handshake:
  - rx_valid && rx_ready clears rx_valid next cycle unless a load coincides.
  - rx_data/flags are held stable while rx_valid && !rx_ready.
- Overrun:
  - Load while rx_valid && !rx_ready: new frame discarded, buffer unchanged, overrun=1 for exactly one cycle.
  - Load in the same cycle as the handshake is not an overrun; the new byte is loaded and rx_valid stays 1.
- busy=1 in every state except IDLE.

Optional Feature:
- UART_RX_GLITCH_FILTER_EN
- Defined: every sample point (start, data, parity, stop) takes the majority of rxs at ticks centre-1, centre, centre+1. The decision applies at centre+1 and tick-count alignment is unchanged. This needs OVERSAMPLE>=4.
- Undefined: single sample at the centre tick; no majority logic synthesised.

Test Plan:
- Byte 0x55, 8N1, baud_div=3, OVERSAMPLE=16 (64 clk/bit) -> rx_valid rises once with rx_data=0x55, frame_err=0, parity_err=0. Handshake with rx_ready=1 drops rx_valid next cycle.
- Parity: parity_en=1, parity_odd=0, byte 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1. Same byte with parity bit 0 -> parity_err=0.
- Frame error/break: byte 0x3C with stop bit 0, line held low for 3 bit times -> rx_data=0x3C, frame_err=1. No new start is accepted until the line returns high; busy=1 through BREAK_WAIT.
- Overrun: send 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, single-cycle overrun pulse at the 0x22 load. Repeat with rx_ready asserted on the load cycle -> rx_data=0x22, no overrun.
- False start: low pulse of 5 oversample ticks -> returns to IDLE, no rx_valid. A following 0x0F frame is received correctly.
- Reset mid-frame: assert rst_n=0 during DATA bit 4 -> all outputs 0, state IDLE. Next full frame 0xC3 is received correctly. With UART_RX_GLITCH_FILTER_EN, a 1-tick glitch at a data-bit centre does not corrupt 0xC3.

Source files
------------

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_engine
// Desc     : Oversampling UART receiver: start/data/parity/stop -> byte on a
//            valid/ready port. Macro UART_RX_GLITCH_FILTER_EN adds 3-tap
//            majority sampling at every bit centre.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  localparam logic [TC_W-1:0] c_half_m1 = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] c_full_m1 = TC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] c_last_bit = BI_W'(DATA_BITS - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;
  localparam logic [2:0] c_st_break  = 3'd5;

  logic                 r_sync1, r_sync2;
  logic                 w_rxs;
  logic [2:0]           r_state, w_state_nxt;
  logic [DIV_W-1:0]     r_div_q, r_cnt;
  logic [TC_W-1:0]      r_tc;
  logic [BI_W-1:0]      r_bidx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en, r_par_odd;
  logic                 r_perr_n, r_ferr_n, r_load;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_perr, r_ovr;
  logic                 w_tick, w_at_cen, w_cen, w_dec, w_bit, w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs  = r_sync2;
  assign w_tick = (r_cnt == r_div_q);

  // Start-bit centre sits half a bit in; all later centres are a full bit apart.
  always_comb begin
    w_at_cen = 1'b0;
    case (r_state)
      c_st_start:                      w_at_cen = (r_tc == c_half_m1);
      c_st_data, c_st_parity, c_st_stop: w_at_cen = (r_tc == c_full_m1);
      default:                         w_at_cen = 1'b0;
    endcase
  end

  assign w_cen = w_tick & w_at_cen;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam logic [TC_W-1:0] c_half_m2 = TC_W'(OVERSAMPLE / 2 - 2);
  localparam logic [TC_W-1:0] c_full_m2 = TC_W'(OVERSAMPLE - 2);

  logic r_s_pre, r_s_cen, r_pend;
  logic w_at_pre;

  always_comb begin
    w_at_pre = 1'b0;
    case (r_state)
      c_st_start:                      w_at_pre = (r_tc == c_half_m2);
      c_st_data, c_st_parity, c_st_stop: w_at_pre = (r_tc == c_full_m2);
      default:                         w_at_pre = 1'b0;
    endcase
  end

  // The decision waits for the centre+1 tick; tc keeps counting from the centre.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_pre <= 1'b1;
      r_s_cen <= 1'b1;
      r_pend  <= 1'b0;
    end else if (r_state == c_st_idle) begin
      r_pend <= 1'b0;
    end else if (w_tick) begin
      if (w_at_pre) r_s_pre <= w_rxs;
      if (w_cen) begin
        r_s_cen <= w_rxs;
        r_pend  <= 1'b1;
      end else begin
        r_pend <= 1'b0;
      end
    end
  end

  assign w_dec = w_tick & r_pend;
  assign w_bit = (r_s_pre & r_s_cen) | (r_s_pre & w_rxs) | (r_s_cen & w_rxs);
`else
  assign w_dec = w_cen;
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (!w_rxs) w_state_nxt = c_st_start;
      c_st_start:  if (w_dec)  w_state_nxt = w_bit ? c_st_idle : c_st_data;
      c_st_data:   if (w_dec && (r_bidx == c_last_bit))
                     w_state_nxt = r_par_en ? c_st_parity : c_st_stop;
      c_st_parity: if (w_dec)  w_state_nxt = c_st_stop;
      c_st_stop:   if (w_dec)  w_state_nxt = w_bit ? c_st_idle : c_st_break;
      c_st_break:  if (w_rxs)  w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = (r_state != c_st_idle);
  end

  // Frame datapath: divisor and framing options are frozen at start detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_q   <= '0;
      r_cnt     <= '0;
      r_tc      <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_perr_n  <= 1'b0;
      r_ferr_n  <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (r_state == c_st_idle) begin
        r_cnt <= '0;
        r_tc  <= '0;
        if (!w_rxs) begin
          r_div_q   <= baud_div;
          r_par_en  <= parity_en;
          r_par_odd <= parity_odd;
          r_perr_n  <= 1'b0;
          r_bidx    <= '0;
        end
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
        if (w_tick) r_tc <= w_cen ? '0 : r_tc + TC_W'(1);
        if (w_dec) begin
          case (r_state)
            c_st_data: begin
              r_shift[r_bidx] <= w_bit;
              r_bidx          <= r_bidx + BI_W'(1);
            end
            c_st_parity: r_perr_n <= (^r_shift) ^ w_bit ^ r_par_odd;
            c_st_stop: begin
              r_ferr_n <= ~w_bit;
              r_load   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // A load into a full, unaccepted buffer is dropped and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_load && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_ferr  <= r_ferr_n;
        r_perr  <= r_perr_n;
        r_valid <= 1'b1;
      end else begin
        if (r_load) r_ovr <= 1'b1;
        if (r_valid && rx_ready) r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_engine
// Desc     : Self-checking bench: frame table + random frames vs. a frame-level
//            model, plus false-start, overrun, break and mid-frame reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_engine;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DIV_W-1:0]     baud_div = 16'd3;
  logic                 parity_en = 1'b0;
  logic                 parity_odd = 1'b0;
  logic                 rx_i = 1'b1;
  logic                 rx_ready = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_engine #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_W     (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_odd;
    logic       par_bit;
    logic       stop_bit;
    int         div;
    int         glitch;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_rec_t;

  int      n_vec = 0;
  int      n_bad = 0;
  rx_rec_t rxq[$];
  int      ovr_cycles = 0;
  int      ovr_pulses = 0;
  int      stuck = 0;
  logic    ovr_prev = 1'b0;
  logic    hs_prev = 1'b0;
  vec_t    vecs[$];

  // Consumer-side observer: bytes accepted, overrun pulses, valid held past a handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) rxq.push_back('{data: rx_data, ferr: frame_err, perr: parity_err});
      if (overrun) ovr_cycles++;
      if (overrun && !ovr_prev) ovr_pulses++;
      if (hs_prev && rx_valid) stuck++;
    end
    ovr_prev = overrun;
    hs_prev  = rx_valid && rx_ready;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, got %0d vectors, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) step();
  endtask

  // Frame-level reference: data as sent, parity error from total count of ones.
  function automatic vec_t model(input logic [7:0] d, input logic pe, input logic po,
                                 input logic pb, input logic sb, input int div, input int gl);
    vec_t v;
    int   ones;
    ones       = $countones(d) + int'(pb) + int'(po);
    v.data     = d;   v.par_en = pe; v.par_odd = po; v.par_bit = pb;
    v.stop_bit = sb;  v.div    = div; v.glitch  = gl;
    v.exp_data = d;
    v.exp_ferr = ~sb;
    v.exp_perr = pe && ((ones % 2) == 1);
    return v;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic pe, input logic po, input logic pb,
                              input logic sb, input int div, input logic [7:0] ed,
                              input logic ef, input logic ep, input int gl);
    vec_t v;
    v.data = d; v.par_en = pe; v.par_odd = po; v.par_bit = pb; v.stop_bit = sb;
    v.div = div; v.glitch = gl; v.exp_data = ed; v.exp_ferr = ef; v.exp_perr = ep;
    return v;
  endfunction

  // Framing inputs and divisor are scrambled mid-frame; only start-detect values count.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic po, input logic pb,
                            input logic sb, input int div, input int gl);
    int bclk;
    int tk;
    bclk = (div + 1) * OVERSAMPLE;
    tk   = div + 1;
    baud_div = DIV_W'(div); parity_en = pe; parity_odd = po;
    drive_bit(1'b0, bclk);
    baud_div = DIV_W'($urandom); parity_en = ~pe; parity_odd = ~po;
    for (int i = 0; i < 8; i++) begin
      if (i == gl) begin
        rx_i = d[i];  repeat (bclk / 2 - 2) step();
        rx_i = ~d[i]; repeat (tk) step();
        rx_i = d[i];  repeat (bclk - bclk / 2 + 2 - tk) step();
      end else begin
        drive_bit(d[i], bclk);
      end
    end
    if (pe) drive_bit(pb, bclk);
    drive_bit(sb, bclk);
    baud_div = DIV_W'(div); parity_en = pe; parity_odd = po;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int      bclk;
    rx_rec_t r;
    bclk = (v.div + 1) * OVERSAMPLE;
    rxq.delete();
    send_frame(v.data, v.par_en, v.par_odd, v.par_bit, v.stop_bit, v.div, v.glitch);
    if (!v.stop_bit) begin
      rx_i = 1'b0;
      repeat (3 * bclk) step();
      check({tag, "_break_busy"}, busy, 1);
    end
    drive_bit(1'b1, bclk);
    check({tag, "_idle"}, busy, 0);
    for (int i = 0; i < 2 * bclk && rxq.size() == 0; i++) step();
    check({tag, "_count"}, rxq.size(), 1);
    if (rxq.size() > 0) r = rxq[0];
    else r = '{data: 8'hxx, ferr: 1'bx, perr: 1'bx};
    check({tag, "_data"}, r.data, v.exp_data);
    check({tag, "_ferr"}, r.ferr, v.exp_ferr);
    check({tag, "_perr"}, r.perr, v.exp_perr);
  endtask

  initial begin
    logic seen_hi, seen_lo;

    repeat (4) step();
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (8) step();

    //          data   pe    po    pb    sb  div  exp   fe    pe  glitch
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'h55, 1'b0, 1'b0, -1));
    vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 3, 8'hA5, 1'b0, 1'b1, -1));
    vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 3, 8'hA5, 1'b0, 1'b0, -1));
    vecs.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 3, 8'h3C, 1'b1, 1'b0, -1));
    vecs.push_back(mk(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 2, 8'h07, 1'b0, 1'b0, -1));
    vecs.push_back(mk(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b1, -1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, -1));
    vecs.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'hFF, 1'b0, 1'b0, -1));
    for (int i = 0; i < 16; i++)
      vecs.push_back(model(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 7) != 0), $urandom_range(0, 3), -1));
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    check("handshake_drop", stuck, 0);

    // False start: 5-tick low pulse, then a real frame.
    rxq.delete();
    baud_div = 16'd3;
    rx_i = 1'b0;
    repeat (5 * 4) step();
    rx_i = 1'b1;
    check("fs_busy", busy, 1);
    repeat (2 * 64) step();
    check("fs_idle", busy, 0);
    check("fs_no_valid", rx_valid, 0);
    check("fs_no_byte", rxq.size(), 0);
    apply_vec(mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'h0F, 1'b0, 1'b0, -1), "fs_next");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    ovr_cycles = 0; ovr_pulses = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
    drive_bit(1'b1, 64);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_none", ovr_pulses, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
    drive_bit(1'b1, 64);
    check("ovr_hold_data", rx_data, 8'h11);
    check("ovr_hold_valid", rx_valid, 1);
    check("ovr_pulses", ovr_pulses, 1);
    check("ovr_width", ovr_cycles, 1);
    check("ovr_no_stuck", stuck, 0);

    // Handshake on the load cycle (the cycle after busy falls): not an overrun.
    seen_hi = 1'b0; seen_lo = 1'b0;
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
      begin
        for (int i = 0; i < 200 && !seen_hi; i++) begin step(); seen_hi = busy; end
        for (int i = 0; i < 1000 && !seen_lo; i++) begin step(); seen_lo = !busy; end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    join
    drive_bit(1'b1, 64);
    check("coinc_busy_rise", seen_hi, 1);
    check("coinc_busy_fall", seen_lo, 1);
    check("coinc_data", rx_data, 8'h22);
    check("coinc_valid", rx_valid, 1);
    check("coinc_no_ovr", ovr_pulses, 1);
    rx_ready = 1'b1;
    repeat (3) step();
    check("coinc_drain", rx_valid, 0);

    // Reset in the middle of data bit 4 of 0xC3.
    rxq.delete();
    baud_div = 16'd3; parity_en = 1'b0;
    drive_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, 64);
    rx_i = 1'b0;
    repeat (32) step();
    rst_n = 1'b0;
    step(); step();
    check("mrst_data", rx_data, 0);
    check("mrst_valid", rx_valid, 0);
    check("mrst_ferr", frame_err, 0);
    check("mrst_perr", parity_err, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_busy", busy, 0);
    rst_n = 1'b1;
    rx_i = 1'b1;
    repeat (128) step();
    check("mrst_idle", busy, 0);
    check("mrst_no_byte", rxq.size(), 0);
    apply_vec(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'hC3, 1'b0, 1'b0, -1), "mrst_next");
`ifdef UART_RX_GLITCH_FILTER_EN
    apply_vec(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'hC3, 1'b0, 1'b0, 2), "glitch_b2");
    apply_vec(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'hC3, 1'b0, 1'b0, 6), "glitch_b6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
